muldiv_unit: RTL

//  Iterative 32-bit multiply/divide unit in EX for MULT/MULTU/DIV/DIVU, owning HI/LO.

---
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit for the EX stage. It owns HI/LO and handles MULT/MULTU/DIV/DIVU.
// Latency: accept edge, then WIDTH step edges, then a DONE edge that writes HI/LO. stall_req holds IF/ID/EX until DONE.
// Backpressure: none inbound. The hazard unit ORs stall_req into the pipeline stalls, and flush_e aborts in any state.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_e,
    input  logic [1:0]       op_e,
    input  logic [WIDTH-1:0] a_e,
    input  logic [WIDTH-1:0] b_e,
    input  logic             flush_e,
    input  logic             mthi_e,
    input  logic             mtlo_e,
    input  logic [WIDTH-1:0] hi_wdata,
    input  logic [WIDTH-1:0] lo_wdata,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div0;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Operand magnitudes; op_e[0] clear selects the signed variants.
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    assign signed_op = ~op_e[0];
    assign a_neg     = signed_op & a_e[WIDTH-1];
    assign b_neg     = signed_op & b_e[WIDTH-1];
    assign a_abs     = a_neg ? -a_e : a_e;
    assign b_abs     = b_neg ? -b_e : b_e;

    // Multiply step: r_hi:r_lo is the running product, and the multiplier shifts out of r_lo.
    logic [WIDTH:0]     mul_sum;
    assign mul_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? b_mag : '0)};

    // Restoring divide step: r_hi holds the remainder, and r_lo shifts dividend bits out and quotient bits in.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    assign div_shift = {r_hi, r_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_mag};

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod     = {r_hi, r_lo};
    assign prod_fix = neg_q ? -prod : prod;
    // With a zero divisor the remainder path already reproduces a_e, so only the quotient needs overriding.
    assign quot_fix = div0 ? '1 : (neg_q ? -r_lo : r_lo);
    assign rem_fix  = neg_r ? -r_hi : r_hi;

    assign stall_req = start_e & (state != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            count  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            b_mag  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mthi_e) hi <= hi_wdata;
                    if (mtlo_e) lo <= lo_wdata;
                    if (start_e && !flush_e) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        count  <= '0;
                        is_div <= op_e[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg & op_e[1];
                        div0   <= op_e[1] & (b_e == '0);
                        b_mag  <= b_abs;
                        r_hi   <= '0;
                        r_lo   <= a_abs;
                    end
                end
                RUN: begin
                    if (flush_e) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (is_div) begin
                            if (!div_diff[WIDTH]) begin
                                r_hi <= div_diff[WIDTH-1:0];
                                r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                            end else begin
                                r_hi <= div_shift[WIDTH-1:0];
                                r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            r_hi <= mul_sum[WIDTH:1];
                            r_lo <= {mul_sum[0], r_lo[WIDTH-1:1]};
                        end
                        count <= count + 1'b1;
                        if (count == LAST) state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!flush_e) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
